axis_fifo_ctrl: RTL

Pointer, flag and handshake controller that turns the single-clock simple dual-port byte RAM into an AXI-Stream FIFO. It accepts beats on a slave AXI-Stream port, writes each beat as one aligned WLEN-byte word, and reads words back through the RAM's registered read port (OREG=1, 1-cycle latency). A 2-entry output buffer gives full throughput on the master port. The RAM instance sits beside this block in the FIFO top level and is driven only by this block.

---
 rtl/axis_fifo_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axis_fifo_ctrl.sv
// AXI-Stream FIFO controller: pointers, flags and handshakes around a simple
// dual-port byte RAM with a registered read port, plus a 2-entry output buffer.
module axis_fifo_ctrl #(
    parameter int unsigned BLEN  = 8,
    parameter int unsigned WLEN  = 4,
    parameter int unsigned DLEN  = BLEN * WLEN,
    parameter int unsigned MLEN  = 1024,
    parameter int unsigned ALEN  = $clog2(MLEN),
    localparam int unsigned DEPTH = MLEN / WLEN,
    localparam int unsigned PLEN  = $clog2(DEPTH) + 1,
    localparam int unsigned CLEN  = $clog2(DEPTH + 2) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [DLEN-1:0] s_axis_tdata,
    input  logic            s_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [DLEN-1:0] m_axis_tdata,
    output logic            m_axis_tlast,
    output logic            o_ram_wen,
    output logic [ALEN-1:0] o_ram_waddr,
    output logic [DLEN-1:0] o_ram_wdata,
    output logic            o_ram_ren,
    output logic [ALEN-1:0] o_ram_raddr,
    input  logic [DLEN-1:0] i_ram_rdata,
    output logic [CLEN-1:0] o_count,
    output logic            o_full,
    output logic            o_empty
);

    localparam int unsigned WSH = $clog2(WLEN);
    localparam int unsigned IW  = PLEN - 1;

    logic [PLEN-1:0] wptr, rptr, ram_used;
    logic [DEPTH-1:0] tlast_mem;
    logic            inflight, rd_last;
    logic [1:0]      ob_cnt;
    logic [DLEN-1:0] ob_data0, ob_data1;
    logic            ob_last0, ob_last1;
    logic            wr, pop, push;
    logic [2:0]      ob_occ;

    assign ram_used      = wptr - rptr;
    assign o_full        = (ram_used == PLEN'(DEPTH));
    assign s_axis_tready = rstn & ~o_full;
    assign wr            = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = inflight;

    assign o_ram_wen   = wr;
    assign o_ram_waddr = ALEN'(wptr[IW-1:0]) << WSH;
    assign o_ram_wdata = s_axis_tdata;

    // Buffer slots committed for the next cycle, net of this cycle's pop
    assign ob_occ      = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
    assign o_ram_ren   = rstn & (ram_used != '0) & (ob_occ < 3'd2);
    assign o_ram_raddr = ALEN'(rptr[IW-1:0]) << WSH;

    assign m_axis_tvalid = (ob_cnt != 2'd0);
    assign m_axis_tdata  = ob_data0;
    assign m_axis_tlast  = ob_last0;

    assign o_count = CLEN'(ram_used) + CLEN'(inflight) + CLEN'(ob_cnt);
    assign o_empty = (o_count == '0);

    // Sideband tlast storage, not cleared by reset
    always_ff @(posedge clk) begin
        if (wr) tlast_mem[wptr[IW-1:0]] <= s_axis_tlast;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + PLEN'(1);
            inflight <= o_ram_ren;
            if (o_ram_ren) begin
                rptr    <= rptr + PLEN'(1);
                rd_last <= tlast_mem[rptr[IW-1:0]];
            end
        end
    end

    // Output buffer: slot 0 is the head, slot 1 shifts in behind it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ob_cnt   <= 2'd0;
            ob_data0 <= '0;
            ob_data1 <= '0;
            ob_last0 <= 1'b0;
            ob_last1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) begin
                        ob_data0 <= i_ram_rdata;
                        ob_last0 <= rd_last;
                    end else begin
                        ob_data1 <= i_ram_rdata;
                        ob_last1 <= rd_last;
                    end
                end
                2'b01: begin
                    ob_data0 <= ob_data1;
                    ob_last0 <= ob_last1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob_data0 <= i_ram_rdata;
                        ob_last0 <= rd_last;
                    end else begin
                        ob_data0 <= ob_data1;
                        ob_last0 <= ob_last1;
                        ob_data1 <= i_ram_rdata;
                        ob_last1 <= rd_last;
                    end
                end
                default: ;
            endcase
            ob_cnt <= 2'(ob_cnt + 2'(push) - 2'(pop));
        end
    end

endmodule
